// File: rtl/rr_requester.sv
// Per-channel pending-job counters that raise requests to an external round-robin
// arbiter, plus a transfer FSM that runs one BURST-beat transfer per accepted grant.
module rr_requester #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [WIDTH-1:0] push,
  input  logic [WIDTH-1:0] grant,
  output logic [WIDTH-1:0] request,
  output logic             ack,
  output logic             beat,
  output logic [WIDTH-1:0] active,
  output logic             busy,
  output logic [WIDTH-1:0] overflow,
  output logic             proto_err
);
  // state | meaning
  // IDLE  | waiting for a one-hot grant to a channel with pending jobs
  // XFER  | driving BURST data beats for the active channel
  // ACK   | one-cycle completion pulse; active channel's job retired
  localparam int PW = $clog2(DEPTH + 1);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [PW-1:0] PEND_MAX  = PW'(DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]                  state;
  logic [BW-1:0]               beat_cnt;
  logic [WIDTH-1:0][PW-1:0]    pend;
  logic [WIDTH-1:0]            dec;
  logic                        grant_one_hot;
  logic                        grant_multi;
  logic                        grant_ok;

  assign grant_one_hot = (grant != '0) && ((grant & (grant - WIDTH'(1))) == '0);
  assign grant_multi   = (grant != '0) && !grant_one_hot;
  assign grant_ok      = grant_one_hot && ((grant & request) != '0);
  assign busy          = (state != IDLE);
  assign dec           = (state == ACK) ? active : '0;

  always_comb begin
    request = '0;
    for (int i = 0; i < WIDTH; i++) begin
      request[i] = (pend[i] != '0);
    end
  end

  // A push that coincides with the retiring job's decrement cancels out, so a
  // full channel accepts it without flagging overflow.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      pend     <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (push[i] && !dec[i]) begin
          if (pend[i] != PEND_MAX) begin
            pend[i] <= pend[i] + PW'(1);
          end else begin
            overflow[i] <= 1'b1;
          end
        end else if (dec[i] && !push[i]) begin
          pend[i] <= pend[i] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      active    <= '0;
      ack       <= 1'b0;
      beat      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_multi) begin
            proto_err <= 1'b1;
          end
          if (grant_ok) begin
            state    <= XFER;
            active   <= grant;
            beat_cnt <= '0;
            beat     <= 1'b1;
          end
        end
        XFER: begin
          if (beat_cnt == BEAT_LAST) begin
            state <= ACK;
            beat  <= 1'b0;
            ack   <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        ACK: begin
          ack    <= 1'b0;
          active <= '0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ack    <= 1'b0;
          beat   <= 1'b0;
          active <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_requester.sv
// Scoreboard bench for rr_requester: a transfer-window reference model predicts
// each transfer and its ack cycle; a monitor checks outputs every cycle.
module tb_rr_requester;
  localparam int W = 4;
  localparam int D = 4;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         resetb = 1'b1;
  logic [W-1:0] push = '0;
  logic [W-1:0] grant = '0;
  logic [W-1:0] request;
  logic         ack;
  logic         beat;
  logic [W-1:0] active;
  logic         busy;
  logic [W-1:0] overflow;
  logic         proto_err;

  rr_requester #(.WIDTH(W), .DEPTH(D), .BURST(B)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .push      (push),
    .grant     (grant),
    .request   (request),
    .ack       (ack),
    .beat      (beat),
    .active    (active),
    .busy      (busy),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int ack_cyc;
  } xfer_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           m_pend [W];
  logic [W-1:0] m_ovf = '0;
  logic         m_perr = 1'b0;
  int           m_start = -100;
  int           m_ch = 0;
  xfer_t        exp_q [$];
  int           beats_seen = 0;
  int           acks_seen = 0;
  logic [W-1:0] acked_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input int got, input int want);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) m_pend[i] = 0;
    m_ovf      = '0;
    m_perr     = 1'b0;
    m_start    = -100;
    m_ch       = 0;
    beats_seen = 0;
    exp_q.delete();
  endtask

  // Reference model: a transfer granted at edge s beats after edges s..s+B-1,
  // acks after edge s+B, retires its job at edge s+B+1, and the FSM may take
  // a new grant from edge s+B+2 on.
  always @(posedge clk) begin : model
    logic [W-1:0] dec_v;
    int           n_set;
    int           k;
    cyc++;
    if (!resetb) begin
      dec_v = '0;
      if (cyc == m_start + B + 1) dec_v[m_ch] = 1'b1;
      if (cyc >= m_start + B + 2) begin
        n_set = $countones(grant);
        if (n_set >= 2) begin
          m_perr = 1'b1;
        end else if (n_set == 1) begin
          k = 0;
          for (int i = 0; i < W; i++) if (grant[i]) k = i;
          if (m_pend[k] > 0) begin
            m_start = cyc;
            m_ch    = k;
            exp_q.push_back('{ch: k, ack_cyc: cyc + B});
          end
        end
      end
      for (int i = 0; i < W; i++) begin
        if (dec_v[i] && !push[i]) begin
          m_pend[i]--;
        end else if (push[i] && !dec_v[i]) begin
          if (m_pend[i] < D) m_pend[i]++;
          else m_ovf[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [W-1:0] exp_req;
    logic         in_x;
    logic         in_beat;
    xfer_t        x;
    if (!resetb) begin
      exp_req = '0;
      for (int i = 0; i < W; i++) exp_req[i] = (m_pend[i] > 0);
      in_x    = (cyc >= m_start) && (cyc <= m_start + B);
      in_beat = (cyc >= m_start) && (cyc <= m_start + B - 1);
      check("request", 32'(request), 32'(exp_req));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("proto_err", 32'(proto_err), 32'(m_perr));
      check("busy", 32'(busy), 32'(in_x));
      check("beat", 32'(beat), 32'(in_beat));
      check("active", 32'(active), in_x ? (32'(1) << m_ch) : 32'(0));
      if (beat) beats_seen++;
      if (ack) begin
        if (exp_q.size() == 0) begin
          fail_event("ack_unexpected", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("ack_channel", 32'(active), 32'(1) << x.ch);
          check("ack_cycle", 32'(cyc), 32'(x.ack_cyc));
          check("ack_beats", 32'(beats_seen), 32'(B));
        end
        beats_seen = 0;
        acks_seen++;
        acked_mask = acked_mask | active;
      end else if (exp_q.size() > 0 && cyc > exp_q[0].ack_cyc) begin
        fail_event("ack_missing", cyc, exp_q[0].ack_cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [W-1:0] p, input logic [W-1:0] g);
    @(negedge clk);
    push  = p;
    grant = g;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive('0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"}, 32'(request), 0);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_beat"}, 32'(beat), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_proto_err"}, 32'(proto_err), 0);
  endtask

  function automatic logic [W-1:0] rr_pick(input logic [W-1:0] req, input int p);
    int c;
    for (int j = 0; j < W; j++) begin
      c = (p + j) % W;
      if (req[c]) return W'(1) << c;
    end
    return '0;
  endfunction

  task automatic run_arbiter(input int n);
    int ptr;
    ptr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push = '0;
      if (ack) begin
        for (int c = 0; c < W; c++) if (active[c]) ptr = (c + 1) % W;
      end
      grant = rr_pick(request, ptr);
    end
    grant = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] p;
    logic [W-1:0] g;
    int           r;
    int           acks_before;
    model_reset();
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    resetb = 1'b0;

    // single job on channel 0
    drive(4'b0001, '0);
    drive('0, 4'b0001);
    idle_cycles(B + 3);
    check("single_request_after", 32'(request), 0);

    // fill channel 2 past its depth, then retire one job
    for (int i = 0; i < 5; i++) drive(4'b0100, '0);
    drive('0, '0);
    check("full_overflow", 32'(overflow), 32'(4'b0100));
    check("full_request", 32'(request[2]), 1);
    drive('0, 4'b0100);
    idle_cycles(B + 3);
    check("full_overflow_kept", 32'(overflow), 32'(4'b0100));

    // push on channel 1 during its own ACK cycle while full
    for (int i = 0; i < 4; i++) drive(4'b0010, '0);
    drive('0, 4'b0010);
    begin : wait_ack
      int k;
      k = 0;
      drive('0, '0);
      while (!ack && k < 20) begin
        drive('0, '0);
        k++;
      end
      if (!ack) fail_event("push_ack_timeout", k, 0);
      push = 4'b0010;
    end
    drive('0, '0);
    idle_cycles(2);
    check("push_ack_overflow1", 32'(overflow[1]), 0);

    // illegal and pointless grants in IDLE
    drive('0, 4'b0011);
    drive('0, '0);
    check("multi_grant_proto_err", 32'(proto_err), 1);
    check("multi_grant_idle", 32'(busy), 0);
    drive('0, 4'b1000);
    drive('0, '0);
    check("empty_grant_idle", 32'(busy), 0);
    check("empty_grant_no_beat", 32'(beat), 0);

    // reset asserted during the second beat
    drive('0, 4'b0010);
    drive('0, '0);
    @(posedge clk);
    #2;
    resetb = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset_mid_xfer");
    @(negedge clk);
    check_all_zero("reset_held");
    resetb = 1'b0;

    // one job per channel served by a round-robin arbiter
    acks_before = acks_seen;
    acked_mask  = '0;
    drive(4'b1111, '0);
    run_arbiter(40);
    check("rr_ack_count", 32'(acks_seen - acks_before), 4);
    check("rr_channels", 32'(acked_mask), 32'(4'b1111));
    check("rr_request_drained", 32'(request), 0);

    // random traffic, then drain through the arbiter
    for (int i = 0; i < 2000; i++) begin
      p = '0;
      for (int c = 0; c < W; c++) p[c] = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 19);
      if (r < 12) g = W'(1) << $urandom_range(0, W - 1);
      else if (r == 12) g = W'(3) << $urandom_range(0, W - 2);
      else g = '0;
      drive(p, g);
    end
    drive('0, '0);
    run_arbiter(200);
    idle_cycles(B + 3);
    check("final_request", 32'(request), 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
